// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared state encodings and constants for the 10101 detector
package seq_detect_pkg;

  localparam int STATE_W = 3;
  localparam int PAT_LEN = 5;

  // Sn means n+1 pattern bits seen; the final state index equals the pattern length.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_S0   = 3'd1,
    ST_S1   = 3'd2,
    ST_S2   = 3'd3,
    ST_S3   = 3'd4,
    ST_S4   = 3'(PAT_LEN)
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer advances past each winner
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;
  logic          found;
  int            c;

  always_comb begin
    grant = '0;
    gidx  = ptr;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        grant[c] = 1'b1;
        gidx     = IW'(c);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// rtl/seq_detect_scheduler.sv - one shared 10101 Moore engine time-multiplexed over NCH serial channels
module seq_detect_scheduler
  import seq_detect_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [NCH-1:0]         req_valid,
  input  logic [NCH-1:0]         req_bit,
  output logic [NCH-1:0]         req_ready,
  input  logic [NCH-1:0]         flush,
  output logic                   match_valid,
  output logic [$clog2(NCH)-1:0] match_ch,
  input  logic [$clog2(NCH)-1:0] cnt_sel,
  output logic [CNT_W-1:0]       cnt_out
);

  localparam int CH_W = $clog2(NCH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NCH-1:0]     arb_req;
  logic [NCH-1:0]     grant;
  logic [STATE_W-1:0] ch_state [NCH];
  logic [CNT_W-1:0]   ch_cnt   [NCH];
  logic [CH_W-1:0]    gidx;
  logic               accept;
  logic               cur_bit;
  logic [STATE_W-1:0] cur;
  logic [STATE_W-1:0] nxt;
  logic               hit;

  // Flushing channels never compete, so they cannot steal or shift the pointer.
  assign arb_req   = req_valid & ~flush & {NCH{enable & resetn}};
  assign req_ready = grant;
  assign accept    = |grant;

  rr_arbiter #(.N(NCH)) u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    (arb_req),
    .grant  (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) gidx = CH_W'(i);
    end
  end

  // Shared engine: load the granted channel's saved state and step it once.
  always_comb begin
    cur     = ch_state[gidx];
    cur_bit = req_bit[gidx];
    nxt     = ST_IDLE;
    case (cur)
      ST_S0:   nxt = cur_bit ? ST_S0 : ST_S1;
      ST_S1:   nxt = cur_bit ? ST_S2 : ST_IDLE;
      ST_S2:   nxt = cur_bit ? ST_S0 : ST_S3;
      ST_S3:   nxt = cur_bit ? ST_S4 : ST_IDLE;
      ST_S4:   nxt = cur_bit ? ST_S0 : ST_S3;
      default: nxt = cur_bit ? ST_S0 : ST_IDLE;
    endcase
    hit = accept && (nxt == ST_S4);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) begin
        ch_state[i] <= ST_IDLE;
        ch_cnt[i]   <= '0;
      end
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else begin
      match_valid <= hit;
      if (hit) match_ch <= gidx;
      for (int i = 0; i < NCH; i++) begin
        if (flush[i]) begin
          ch_state[i] <= ST_IDLE;
          ch_cnt[i]   <= '0;
        end else if (grant[i]) begin
          ch_state[i] <= nxt;
          if (hit && ch_cnt[i] != CNT_MAX) ch_cnt[i] <= ch_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    cnt_out = '0;
    if (int'(cnt_sel) < NCH) cnt_out = ch_cnt[cnt_sel];
  end

endmodule

// File: doc/seq_detect_scheduler.md
SEQ_DETECT_SCHEDULER -- requirements
Module: seq_detect_scheduler

Interface
REQ-001 Parameter NCH, default 4: number of serial requester channels; legal values 2..8.
REQ-002 Parameter CNT_W, default 8: width of each per-channel match counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 resetn  input  1  reset is synchronous and active-low.
REQ-005 enable  input  1  high permits grants; low stalls all channels with state held.
REQ-006 req_valid  input  NCH  per-channel bit-valid.
REQ-007 req_bit  input  NCH  per-channel serial data bit.
REQ-008 req_ready  output  NCH  per-channel grant; one-hot or zero.
REQ-009 flush  input  NCH  per-channel clear of detector state and match counter.
REQ-010 match_valid  output  1  one-cycle pulse: a channel completed pattern 10101.
REQ-011 match_ch  output  clog2(NCH)  channel index qualified by match_valid.
REQ-012 cnt_sel  input  clog2(NCH)  match-counter read select.
REQ-013 cnt_out  output  CNT_W  match count of channel cnt_sel, combinational read.

Function
REQ-014 One shared Moore engine detects 10101 with overlap and is time-multiplexed across channels; each channel's 3-bit state is saved in a per-channel state register.
REQ-015 Engine states: IDLE=0, S0=1, S1=2, S2=3, S3=4, S4=5.
REQ-016 Transitions on bit 1/0: IDLE->S0/IDLE; S0->S0/S1; S1->S2/IDLE; S2->S0/S3; S3->S4/IDLE; S4->S0/S3.
REQ-017 Unused state encodings 6 and 7 behave as IDLE.
REQ-018 Arbitration: round-robin among channels with req_valid high, flush low and enable high; at most one grant per cycle.
REQ-019 req_ready[i] is combinational and high only for the granted channel; a bit is accepted when req_valid[i] and req_ready[i] are both high.
REQ-020 Priority pointer: after a grant to channel i, channel (i+1) mod NCH is highest priority next cycle; with no grant the pointer holds.
REQ-021 On acceptance, channel i's saved state is updated to the engine next-state; the states of all other channels are unchanged.
REQ-022 If the next-state is S4, match_valid=1 and match_ch=i are asserted on the following cycle (latency 1); otherwise match_valid=0.
REQ-023 match_ch holds its last value when match_valid is 0.
REQ-024 On each match, counter[i] increments by 1 and saturates at 2^CNT_W-1.
REQ-025 flush[i] sets channel i state to IDLE and counter[i] to 0 next cycle.
REQ-026 flush[i] masks the request from channel i that cycle, so there is no grant, no match and no pointer change for i.
REQ-027 flush of one channel does not affect arbitration of the other channels in the same cycle.
REQ-028 enable low: req_ready=0; states, counters and pointer hold; a match pulse already registered still appears.
REQ-029 Reset mid-stream discards all partial sequences, and any pending match pulse is suppressed.

Reset
REQ-030 When resetn=0 at a clock edge: all channel states go to IDLE, all counters to 0, the pointer to channel 0, match_valid to 0 and match_ch to 0.
REQ-031 req_ready is 0 while resetn is low.

Structure
REQ-032 The state encodings (IDLE..S4), the state width constant (3) and the pattern-length constant (5) are placed in the shared package seq_detect_pkg.
REQ-033 The round-robin arbiter is the single sub-module, rr_arbiter: NCH request vector in, one-hot grant vector out, internal pointer.
REQ-034 The engine next-state and match logic is combinational inside the top module; no per-channel engine copies are instantiated.

Verification
REQ-035 Single channel 0, enable=1, stream 1,0,1,0,1,0,1 with no gaps -> match_valid pulses one cycle after the 5th bit and one cycle after the 7th bit, match_ch=0 both times, cnt_out(sel=0)=2.
REQ-036 All 4 channels valid continuously -> grants follow the order 0,1,2,3,0; each channel is accepted every 4th cycle, and interleaved 10101 streams produce per-channel matches with correct match_ch values.
REQ-037 Channel 2 has received 1,0,1,0; assert flush[2] while req_valid[2]=1 -> req_ready[2]=0 that cycle; after a following 1, no match occurs and the channel 2 state is S0.
REQ-038 Channel 1 counter at 255 (CNT_W=8) plus one further match -> cnt_out stays at 255 and match_valid still pulses.
REQ-039 enable dropped for 3 cycles in the middle of a stream on channel 3 -> no grants during those cycles, and the stream resumes and completes a match exactly as if there were no gap.
REQ-040 resetn=0 for one cycle after the 4th bit of 1,0,1,0,1 -> no match follows the 5th bit, and all counters read 0.
